// File: rtl/phy_pkg.sv
// phy_pkg: shared constants and state encoding for the PHY serial receive path
package phy_pkg;
  localparam logic [7:0] COMMA = 8'hBC;
  localparam int WORD_W = 9;
  typedef enum logic [1:0] {
    INIT   = 2'd0,
    SYNC   = 2'd1,
    ACTIVE = 2'd2
  } state_t;
endpackage

// File: rtl/phy_rx_comma_align.sv
// phy_rx_comma_align: serial shift register, byte-phase counter and comma alignment FSM
module phy_rx_comma_align
  import phy_pkg::*;
#(
  parameter int BC_COUNT = 4
) (
  input  logic       clk32f,
  input  logic       reset,
  input  logic       data_in,
  output logic       boundary,
  output logic [7:0] cand,
  output logic       active,
  output logic       sync_err
);
  localparam logic [3:0] BC_LAST = 4'(BC_COUNT);

  state_t     state_q, state_d;
  logic [7:0] sr_q, sr_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] bc_cnt_q, bc_cnt_d;
  logic       active_q, active_d;
  logic       sync_err_q, sync_err_d;

  assign cand     = {sr_q[6:0], data_in};
  assign boundary = (state_q == ACTIVE) && (bit_cnt_q == 3'd7);
  assign active   = active_q;
  assign sync_err = sync_err_q;

  // hunt for a comma, count aligned commas, then free-run the byte phase once active
  always_comb begin
    sr_d       = cand;
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q + 3'd1;
    bc_cnt_d   = bc_cnt_q;
    active_d   = active_q;
    sync_err_d = sync_err_q;
    unique case (state_q)
      INIT: begin
        bit_cnt_d = 3'd0;
        if (cand == COMMA) begin
          state_d  = SYNC;
          bc_cnt_d = 4'd1;
        end
      end
      SYNC: begin
        if (bit_cnt_q == 3'd7) begin
          if (cand == COMMA) begin
            bc_cnt_d = bc_cnt_q + 4'd1;
            if (bc_cnt_q + 4'd1 == BC_LAST) begin
              state_d  = ACTIVE;
              active_d = 1'b1;
            end
          end else begin
            state_d    = INIT;
            bc_cnt_d   = 4'd0;
            bit_cnt_d  = 3'd0;
            sync_err_d = 1'b1;
          end
        end
      end
      ACTIVE: ;
      default: begin
        state_d   = INIT;
        bit_cnt_d = 3'd0;
      end
    endcase
  end

  // alignment state; a low reset discards any partial byte immediately
  always_ff @(posedge clk32f or negedge reset) begin
    if (!reset) begin
      state_q    <= INIT;
      sr_q       <= 8'h00;
      bit_cnt_q  <= 3'd0;
      bc_cnt_q   <= 4'd0;
      active_q   <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      bit_cnt_q  <= bit_cnt_d;
      bc_cnt_q   <= bc_cnt_d;
      active_q   <= active_d;
      sync_err_q <= sync_err_d;
    end
  end
endmodule

// File: rtl/phy_rx_serial_paralelo.sv
// phy_rx_serial_paralelo: one-lane serial-to-parallel receiver with comma alignment
module phy_rx_serial_paralelo
  import phy_pkg::*;
#(
  parameter int BC_COUNT = 4
) (
  input  logic              clk32f,
  input  logic              reset,
  input  logic              data_in,
  output logic [WORD_W-1:0] paralelo_out,
  output logic              word_strobe,
  output logic              active,
  output logic              sync_err
);
  logic              boundary;
  logic [7:0]        cand;
  logic [WORD_W-1:0] paralelo_q, paralelo_d;
  logic              word_strobe_q, word_strobe_d;

  phy_rx_comma_align #(.BC_COUNT(BC_COUNT)) u_align (
    .clk32f   (clk32f),
    .reset    (reset),
    .data_in  (data_in),
    .boundary (boundary),
    .cand     (cand),
    .active   (active),
    .sync_err (sync_err)
  );

  assign paralelo_out = paralelo_q;
  assign word_strobe  = word_strobe_q;

  // on an active byte boundary capture the byte; a comma is idle and marked invalid
  always_comb begin
    paralelo_d    = boundary ? {cand != COMMA, cand} : paralelo_q;
    word_strobe_d = boundary;
  end

  // output word and strobe registers
  always_ff @(posedge clk32f or negedge reset) begin
    if (!reset) begin
      paralelo_q    <= '0;
      word_strobe_q <= 1'b0;
    end else begin
      paralelo_q    <= paralelo_d;
      word_strobe_q <= word_strobe_d;
    end
  end
endmodule
